// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_pkg
// Brief    : Shared defaults and FSM state type for sram_rw_arbiter.
// Revision : 1.0
// ============================================================================
package sram_arb_pkg;

    localparam int ADDR_W_DEFAULT     = 12;
    localparam int DATA_W_DEFAULT     = 137;
    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int RSP_FIFO_DEPTH     = 2;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/array_19_ext.sv
`default_nettype none
// ============================================================================
// Module   : array_19_ext
// Brief    : Single-port synchronous SRAM, one access per cycle, 1-cycle read.
// Revision : 1.0
// ============================================================================
module array_19_ext #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 137
) (
    input  logic              RW0_clk,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [DATA_W-1:0] RW0_wdata,
    output logic [DATA_W-1:0] RW0_rdata
);

    logic [DATA_W-1:0] mem_q [1<<ADDR_W];

    // Contents carry no reset; read data holds until the next read.
    always_ff @(posedge RW0_clk) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                mem_q[RW0_addr] <= RW0_wdata;
            end else begin
                RW0_rdata <= mem_q[RW0_addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_rw_arbiter
// Brief    : Read/write arbiter for one single-port SRAM with a 2-entry read
//            response FIFO. Define SRAM_INIT_EN to zero-sweep the SRAM after reset.
// Revision : 1.0
// ============================================================================
module sram_rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);
`ifdef SRAM_INIT_EN
    localparam arb_state_t RESET_STATE = INIT;
`else
    localparam arb_state_t RESET_STATE = RUN;
`endif

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                inflight_q, inflight_d;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic                fifo_wptr_q, fifo_wptr_d;
    logic                fifo_rptr_q, fifo_rptr_d;
    logic [DATA_W-1:0]   fifo_mem_q [RSP_FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_mem_d [RSP_FIFO_DEPTH];
`ifdef SRAM_INIT_EN
    logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
`endif

    logic                force_wr;
    logic                rd_room;
    logic [2:0]          rd_occ;
    logic                rd_grant;
    logic                wr_grant;
    logic                init_wr;
    logic                fifo_push;
    logic                fifo_pop;
    logic                sram_en;
    logic                sram_wmode;
    logic [ADDR_W-1:0]   sram_addr;
    logic [DATA_W-1:0]   sram_wdata;
    logic [DATA_W-1:0]   sram_rdata;

    always_comb begin
        init_done = (state_q == RUN) && !reset;
`ifdef SRAM_INIT_EN
        init_wr   = (state_q == INIT) && !reset;
`else
        init_wr   = 1'b0;
`endif
        rsp_valid = (fifo_cnt_q != 2'd0);
        rsp_data  = fifo_mem_q[fifo_rptr_q];
        fifo_pop  = rsp_valid && rsp_ready;
        fifo_push = inflight_q;

        // A same-cycle pop frees its slot, so back-to-back reads can stream.
        rd_occ    = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, fifo_pop};
        rd_room   = (rd_occ < 3'd2);
        force_wr  = wr_valid && (starve_q == STARVE_LIMIT);

        rd_ready  = init_done && rd_room && !force_wr;
        wr_ready  = init_done && (force_wr || !(rd_valid && rd_room));
        rd_grant  = rd_valid && rd_ready;
        wr_grant  = wr_valid && wr_ready;

        sram_en    = rd_grant || wr_grant || init_wr;
        sram_wmode = wr_grant || init_wr;
        sram_addr  = wr_grant ? wr_addr : rd_addr;
        sram_wdata = init_wr ? '0 : wr_data;
`ifdef SRAM_INIT_EN
        if (init_wr) begin
            sram_addr = init_addr_q;
        end
`endif

        if (!wr_valid || wr_grant) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIMIT) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end

        inflight_d  = rd_grant;
        fifo_mem_d  = fifo_mem_q;
        fifo_wptr_d = fifo_wptr_q;
        fifo_rptr_d = fifo_rptr_q;
        if (fifo_push) begin
            fifo_mem_d[fifo_wptr_q] = sram_rdata;
            fifo_wptr_d             = ~fifo_wptr_q;
        end
        if (fifo_pop) begin
            fifo_rptr_d = ~fifo_rptr_q;
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};

        state_d = state_q;
`ifdef SRAM_INIT_EN
        init_addr_d = init_addr_q;
        if (state_q == INIT) begin
            init_addr_d = init_addr_q + 1'b1;
            if (init_addr_q == {ADDR_W{1'b1}}) begin
                state_d = RUN;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            starve_q    <= '0;
            inflight_q  <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
`ifdef SRAM_INIT_EN
            init_addr_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            inflight_q  <= inflight_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_wptr_q <= fifo_wptr_d;
            fifo_rptr_q <= fifo_rptr_d;
`ifdef SRAM_INIT_EN
            init_addr_q <= init_addr_d;
`endif
        end
        fifo_mem_q <= fifo_mem_d;
    end

    // Read admission keeps occupancy plus in-flight at or below two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(fifo_push && !fifo_pop && (fifo_cnt_q == 2'd2)));
        end
    end

    array_19_ext #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram (
        .RW0_clk   (clock),
        .RW0_addr  (sram_addr),
        .RW0_en    (sram_en),
        .RW0_wmode (sram_wmode),
        .RW0_wdata (sram_wdata),
        .RW0_rdata (sram_rdata)
    );

endmodule
`default_nettype wire
